asynch_fifo_wr_ctrl: RTL and testbench
======================================

// Module: asynch_fifo_wr_ctrl
// PURPOSE
//  Write-domain pointer/flag controller of the async FIFO; upstream counterpart of the read-side controller.
//  Owns the binary write pointer and produces the memory write address/enable.
//  Publishes a registered Gray write pointer for the 2-FF synchroniser into the read domain.
//  Derives full, almost-full, fill level, overflow and peak-fill status from the synchronised Gray read pointer.
// PARAMETERS
//  PTR_SIZE   4  pointer width; MSB is the wrap bit; DEPTH = 2**(PTR_SIZE-1); legal >= 2
//  AF_THRESH  6  walmost_full asserts when wlevel >= AF_THRESH; legal 1..DEPTH
// PORTS
//  wclk           in   1           write clock; all state on rising edge
//  wrst_n         in   1           synchronous active-low reset, sampled on posedge wclk
//  winc           in   1           write request for the current cycle
//  wq2_gray_rptr  in   PTR_SIZE    read pointer (Gray), already 2-FF synchronised into wclk
//  wclr           in   1           clears woverflow and wpeak
//  waddr          out  PTR_SIZE-1  memory write address = bn_wptr[PTR_SIZE-2:0] (combinational)
//  wen            out  1           memory write enable = winc & ~wfull (combinational)
//  gray_wr_ptr    out  PTR_SIZE    registered Gray write pointer, to synchroniser
//  wfull          out  1           FIFO full (combinational from registers + wq2_gray_rptr)
//  walmost_full   out  1           wlevel >= AF_THRESH (combinational)
//  wlevel         out  PTR_SIZE    fill level 0..DEPTH as seen from the write side
//  woverflow      out  1           sticky: a write was attempted while wfull
//  wpeak          out  PTR_SIZE    highest wlevel observed since reset/wclr (registered)
// BEHAVIOUR
//  - Reset (wrst_n=0 at posedge): bn_wptr=0, gray_wr_ptr=0, woverflow=0, wpeak=0.
//    Hence waddr=0 and wlevel=0 (given rptr 0); wfull=0.
//    Reset overrides winc and wclr. Reset mid-operation discards the pointer; memory contents are not touched.
//  - Gray: gray_wr_ptr holds bn^(bn>>1) of the current bn_wptr.
//    Both registers update on the same edge, so gray_wr_ptr is glitch-free, with one bit changing per write.
//  - Full: wfull = (gray_wr_ptr == {~wq2_gray_rptr[PTR_SIZE-1:PTR_SIZE-2], wq2_gray_rptr[PTR_SIZE-3:0]}).
//    For PTR_SIZE=2 the low slice is empty.
//  - Write: if winc & ~wfull at posedge, the memory captures data at waddr; bn_wptr += 1 (mod 2**PTR_SIZE).
//    Zero latency: address and enable are valid in the request cycle. Pointer and flags update 1 cycle later.
//  - winc & wfull: no pointer change and wen=0; woverflow<=1 on that edge.
//  - Level: rbin = Gray-to-binary(wq2_gray_rptr) (XOR prefix from MSB); wlevel = (bn_wptr - rbin) mod 2**PTR_SIZE.
//    - wlevel==DEPTH iff wfull.
//    - The level is pessimistic: reads appear 2+ wclk late; it never under-reports free space as larger.
//  - wpeak: each posedge, if wlevel > wpeak then wpeak <= wlevel.
//  - wclr at posedge: woverflow<=0 and wpeak<=wlevel (current).
//    If wclr coincides with an overflowing write, set wins: woverflow=1.
//  - Wrap-around: bn_wptr rolls over at 2**PTR_SIZE-1 -> 0; the MSB toggle is what distinguishes full from empty.
//  - wq2_gray_rptr may change on any cycle; all outputs follow combinationally with no extra state.
// TESTING  (PTR_SIZE=4, AF_THRESH=6, DEPTH=8)
//  1 Reset: drive winc=1, wrst_n=0 for 2 edges.
//    -> gray_wr_ptr=0, waddr=0, wlevel=0, wfull=0, woverflow=0, wpeak=0; no pointer movement.
//  2 Fill: rptr=4'b0000, winc=1 for 8 cycles.
//    -> waddr 0..7 with wen=1; after 6 writes walmost_full=1.
//    -> after 8 writes gray_wr_ptr=4'b1100, wfull=1, wlevel=8, wpeak=8.
//  3 Overflow: from full, winc=1 for 1 cycle.
//    -> wen=0, gray_wr_ptr stays 4'b1100, woverflow=1.
//    -> then wclr=1 -> woverflow=0, wpeak=8.
//  4 Drain visibility: from full, set rptr=4'b0010 (bin 3).
//    -> wfull=0, wlevel=5, walmost_full=0; one write -> wlevel=6, walmost_full=1.
//  5 Wrap: with bn_wptr=15 (gray 4'b1000) and rptr gray 4'b1101 (bin 9), wlevel=6.
//    -> one write -> bn_wptr=0, gray_wr_ptr=4'b0000, waddr=0, wlevel=7.
//  6 Reset mid-fill: after 5 writes assert wrst_n=0 for 1 edge, with winc=1 and wclr=1.
//    -> all registered outputs return to 0; the next write uses waddr=0.

Source files
------------

// File: rtl/asynch_fifo_wr_ctrl.sv
// Write-side pointer and flag controller of an asynchronous FIFO.
// Owns the binary write pointer and drives the memory write port.
// Publishes a registered Gray write pointer toward the read domain.
// Derives full, almost-full, level, overflow and peak status from the
// read pointer, which arrives already synchronised into this clock domain.
module asynch_fifo_wr_ctrl #(
    parameter int unsigned PTR_SIZE  = 4,
    parameter int unsigned AF_THRESH = 6
) (
    input  logic                i_wclk,
    input  logic                i_wrst_n,
    input  logic                i_winc,
    input  logic [PTR_SIZE-1:0] i_wq2_gray_rptr,
    input  logic                i_wclr,
    output logic [PTR_SIZE-2:0] o_waddr,
    output logic                o_wen,
    output logic [PTR_SIZE-1:0] o_gray_wr_ptr,
    output logic                o_wfull,
    output logic                o_walmost_full,
    output logic [PTR_SIZE-1:0] o_wlevel,
    output logic                o_woverflow,
    output logic [PTR_SIZE-1:0] o_wpeak
);

    // Full when the write pointer sits exactly one lap ahead of the read pointer.
    // In Gray code a one-lap offset flips the top two bits.
    localparam logic [PTR_SIZE-1:0] FullMask = PTR_SIZE'(3) << (PTR_SIZE - 2);
    localparam logic [PTR_SIZE-1:0] AfThresh = PTR_SIZE'(AF_THRESH);

    logic [PTR_SIZE-1:0] r_bn_wptr;
    logic [PTR_SIZE-1:0] r_gray_wptr;
    logic                r_overflow;
    logic [PTR_SIZE-1:0] r_peak;

    logic [PTR_SIZE-1:0] w_bn_next;
    logic [PTR_SIZE-1:0] w_gray_next;
    logic [PTR_SIZE-1:0] w_rbin;
    logic [PTR_SIZE-1:0] w_level;
    logic                w_full;
    logic                w_wen;

    // Convert the synchronised Gray read pointer to binary (XOR prefix from MSB).
    always_comb begin
        w_rbin = '0;
        w_rbin[PTR_SIZE-1] = i_wq2_gray_rptr[PTR_SIZE-1];
        for (int i = PTR_SIZE - 2; i >= 0; i--) begin
            w_rbin[i] = w_rbin[i+1] ^ i_wq2_gray_rptr[i];
        end
    end

    // Flags, level and next pointer values, all combinational from current state.
    always_comb begin
        w_full      = (r_gray_wptr == (i_wq2_gray_rptr ^ FullMask));
        w_wen       = i_winc & ~w_full;
        w_level     = r_bn_wptr - w_rbin;
        w_bn_next   = w_wen ? (r_bn_wptr + 1'b1) : r_bn_wptr;
        w_gray_next = w_bn_next ^ (w_bn_next >> 1);
    end

    // Binary and Gray pointers advance together so the Gray copy never glitches.
    always_ff @(posedge i_wclk) begin
        if (!i_wrst_n) begin
            r_bn_wptr   <= '0;
            r_gray_wptr <= '0;
        end else begin
            r_bn_wptr   <= w_bn_next;
            r_gray_wptr <= w_gray_next;
        end
    end

    // Sticky overflow: a rejected write sets it, and setting beats a same-cycle clear.
    always_ff @(posedge i_wclk) begin
        if (!i_wrst_n) begin
            r_overflow <= 1'b0;
        end else if (i_winc && w_full) begin
            r_overflow <= 1'b1;
        end else if (i_wclr) begin
            r_overflow <= 1'b0;
        end
    end

    // Peak tracker: clear restarts it from the present level.
    always_ff @(posedge i_wclk) begin
        if (!i_wrst_n) begin
            r_peak <= '0;
        end else if (i_wclr) begin
            r_peak <= w_level;
        end else if (w_level > r_peak) begin
            r_peak <= w_level;
        end
    end

    // Output assignments.
    always_comb begin
        o_waddr        = r_bn_wptr[PTR_SIZE-2:0];
        o_wen          = w_wen;
        o_gray_wr_ptr  = r_gray_wptr;
        o_wfull        = w_full;
        o_walmost_full = (w_level >= AfThresh);
        o_wlevel       = w_level;
        o_woverflow    = r_overflow;
        o_wpeak        = r_peak;
    end

endmodule

// File: tb/tb_asynch_fifo_wr_ctrl.sv
// Bench for the async FIFO write controller (PTR_SIZE=4, AF_THRESH=6).
// The reference model tracks write/read counts as plain integers.
module tb_asynch_fifo_wr_ctrl;

    logic       clk = 1'b0;
    logic       i_wrst_n;
    logic       i_winc;
    logic [3:0] i_wq2_gray_rptr;
    logic       i_wclr;
    logic [2:0] o_waddr;
    logic       o_wen;
    logic [3:0] o_gray_wr_ptr;
    logic       o_wfull;
    logic       o_walmost_full;
    logic [3:0] o_wlevel;
    logic       o_woverflow;
    logic [3:0] o_wpeak;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: writes and reads accepted so far (mod 16), sticky flag, peak.
    int m_wcnt = 0;
    int m_rcnt = 0;
    int m_ovf  = 0;
    int m_peak = 0;

    asynch_fifo_wr_ctrl #(
        .PTR_SIZE  (4),
        .AF_THRESH (6)
    ) dut (
        .i_wclk          (clk),
        .i_wrst_n        (i_wrst_n),
        .i_winc          (i_winc),
        .i_wq2_gray_rptr (i_wq2_gray_rptr),
        .i_wclr          (i_wclr),
        .o_waddr         (o_waddr),
        .o_wen           (o_wen),
        .o_gray_wr_ptr   (o_gray_wr_ptr),
        .o_wfull         (o_wfull),
        .o_walmost_full  (o_walmost_full),
        .o_wlevel        (o_wlevel),
        .o_woverflow     (o_woverflow),
        .o_wpeak         (o_wpeak)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] to_gray(input int b);
        int v;
        v = b & 15;
        return 4'(v ^ (v >> 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, check outputs against the model, clock, update model.
    task automatic step(input logic rst_n, input logic inc, input logic clr, input bit do_chk);
        int  lvl;
        bit  full;
        bit  wen;
        i_wrst_n        = rst_n;
        i_winc          = inc;
        i_wclr          = clr;
        i_wq2_gray_rptr = to_gray(m_rcnt);
        #1;
        lvl  = (m_wcnt - m_rcnt) & 15;
        full = (lvl == 8);
        wen  = inc && !full;
        if (do_chk) begin
            chk("wen",   o_wen,          32'(wen));
            chk("waddr", o_waddr,        32'(m_wcnt & 7));
            chk("wfull", o_wfull,        32'(full));
            chk("af",    o_walmost_full, 32'(lvl >= 6));
            chk("level", o_wlevel,       32'(lvl));
            chk("gray",  o_gray_wr_ptr,  32'(to_gray(m_wcnt)));
            chk("ovf",   o_woverflow,    32'(m_ovf));
            chk("peak",  o_wpeak,        32'(m_peak));
        end
        @(posedge clk);
        if (!rst_n) begin
            m_wcnt = 0;
            m_ovf  = 0;
            m_peak = 0;
        end else begin
            if (inc && full) m_ovf = 1;
            else if (clr)    m_ovf = 0;
            if (clr)              m_peak = lvl;
            else if (lvl > m_peak) m_peak = lvl;
            if (wen) m_wcnt = (m_wcnt + 1) & 15;
        end
        @(negedge clk);
    endtask

    initial begin
        // 1: reset with a write request pending
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("rst_gray", o_gray_wr_ptr, 32'h0);
        chk("rst_ovf",  o_woverflow,   32'h0);
        chk("rst_peak", o_wpeak,       32'h0);

        // 2: fill from empty
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("fill_gray",  o_gray_wr_ptr, 32'hC);
        chk("fill_full",  o_wfull,       32'h1);
        chk("fill_level", o_wlevel,      32'h8);

        // 3: overflow attempt, then clear
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("ovf_gray", o_gray_wr_ptr, 32'hC);
        chk("ovf_set",  o_woverflow,   32'h1);
        chk("ovf_peak", o_wpeak,       32'h8);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("clr_ovf",  o_woverflow,   32'h0);
        chk("clr_peak", o_wpeak,       32'h8);

        // 4: reads become visible (read pointer binary 3)
        m_rcnt = 3;
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("drain_level", o_wlevel,       32'h6);
        chk("drain_af",    o_walmost_full, 32'h1);

        // 5: wrap-around; write pointer 9 -> 15 with read pointer 9
        m_rcnt = 9;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("wrap_pre_gray",  o_gray_wr_ptr, 32'h8);
        chk("wrap_pre_level", o_wlevel,      32'h6);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("wrap_gray",  o_gray_wr_ptr, 32'h0);
        chk("wrap_addr",  o_waddr,       32'h0);
        chk("wrap_level", o_wlevel,      32'h7);

        // 6: reset in the middle of a fill, with write and clear requested
        m_rcnt = 0;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("mrst_gray", o_gray_wr_ptr, 32'h0);
        chk("mrst_addr", o_waddr,       32'h0);
        chk("mrst_peak", o_wpeak,       32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b1);

        // Random traffic: reads only consume what was written
        for (int n = 0; n < 400; n++) begin
            logic rst_n;
            if (((m_wcnt - m_rcnt) & 15) > 0 && $urandom_range(0, 2) == 0)
                m_rcnt = (m_rcnt + 1) & 15;
            rst_n = ($urandom_range(0, 59) != 0);
            if (!rst_n) m_rcnt = 0;
            step(rst_n, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
